lpc_record_fifo: RTL and testbench

Parametrised successor to the fixed 5-bit ringbuffer plus mem2serial path. It takes decoded LPC cycles (cyctype_dir, address, data) into a record FIFO of configurable depth and address width. It serialises each record as a variable-length byte stream to the uart_tx ready/latch handshake. Unlike the previous path, dropped cycles are counted and reported in-band, and overflow is visible per record.

---
 rtl/lpc_pkg.sv | 34 +++
 rtl/lpc_record_ram.sv | 30 +++
 rtl/lpc_record_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_lpc_record_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC record FIFO: read FSM states,
// header layout and drop counter width.
`default_nettype none

package lpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DROP   = 3'd2,
    ST_ADDR   = 3'd3,
    ST_DATA   = 3'd4,
    ST_RETIRE = 3'd5
  } rd_state_t;

  localparam int DROP_FLAG_BIT = 7;
  localparam int CYCTYPE_MSB   = 3;
  localparam int CYCTYPE_LSB   = 0;
  localparam int CYCTYPE_W     = CYCTYPE_MSB - CYCTYPE_LSB + 1;
  localparam int DROP_CNT_W    = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic logic [7:0] make_header(input logic drop_flag,
                                             input logic [CYCTYPE_W-1:0] cyctype);
    logic [7:0] hdr;
    hdr = '0;
    hdr[DROP_FLAG_BIT] = drop_flag;
    hdr[CYCTYPE_MSB:CYCTYPE_LSB] = cyctype;
    return hdr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_record_ram.sv
// Simple dual-port record store: synchronous write, registered read.
`default_nettype none

module lpc_record_ram #(
  parameter int WIDTH = 44,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/lpc_record_fifo.sv
// lpc_record_fifo: buffers decoded LPC cycles and serialises each as a
// variable-length byte record to uart_tx. Optional filter: LPC_ADDR_FILTER_EN.
`default_nettype none

module lpc_record_fifo
  import lpc_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          DEPTH_LOG2   = 5,
  parameter logic [31:0] FILTER_MASK  = 32'h0000_0000,
  parameter logic [31:0] FILTER_MATCH = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            in_cyctype_dir,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_latch,
  input  logic                  uart_ready,
  output logic [7:0]            uart_data,
  output logic                  uart_latch,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int REC_W      = CYCTYPE_W + ADDR_W + 8;
  localparam int PTR_W      = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] LEVEL_FULL = PTR_W'(DEPTH);
  localparam logic [2:0]       LAST_BYTE  = 3'(ADDR_BYTES - 1);

  rd_state_t              state, state_next;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [2:0]             byte_idx, byte_idx_next;
  logic                   drop_pending;
  logic [DROP_CNT_W-1:0]  drop_cnt;
  logic                   overflow_q;
  logic [7:0]             tx_data, tx_data_next;
  logic                   tx_latch, tx_latch_next;

  logic                   addr_ok;
  logic                   full;
  logic                   candidate;
  logic                   push;
  logic                   drop;
  logic                   retire;
  logic                   can_send;
  logic                   drop_report;
  logic [REC_W-1:0]       wr_rec;
  logic [REC_W-1:0]       rd_rec;
  logic [CYCTYPE_W-1:0]   rd_cyctype;
  logic [ADDR_W-1:0]      rd_addr;
  logic [7:0]             rd_byte;
  logic [ADDR_W-1:0]      addr_shifted;

`ifdef LPC_ADDR_FILTER_EN
  assign addr_ok = ((in_addr & FILTER_MASK[ADDR_W-1:0]) ==
                    (FILTER_MATCH[ADDR_W-1:0] & FILTER_MASK[ADDR_W-1:0]));
`else
  // Filter constants fold to a constant 1 here; every pulse is a candidate.
  assign addr_ok = ~&{1'b0, FILTER_MASK[0], FILTER_MATCH[0]};
`endif

  assign level       = wr_ptr - rd_ptr;
  assign empty       = (level == '0);
  assign full        = (level == LEVEL_FULL);
  assign retire      = (state == ST_RETIRE);
  assign candidate   = in_latch & addr_ok;
  // The retiring slot frees up in the same edge, so a full FIFO still accepts.
  assign push        = candidate & (~full | retire);
  assign drop        = candidate & full & ~retire;
  // uart_tx drops ready within a cycle of a latch, so that cycle is ignored.
  assign can_send    = uart_ready & ~tx_latch;
  assign drop_report = (state == ST_DROP) & can_send;

  assign wr_rec     = {in_cyctype_dir, in_addr, in_data};
  assign rd_cyctype = rd_rec[REC_W-1 -: CYCTYPE_W];
  assign rd_addr    = rd_rec[8 +: ADDR_W];
  assign rd_byte    = rd_rec[7:0];

  lpc_record_ram #(
    .WIDTH (REC_W),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (rd_rec)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      tx_latch <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_next;
      byte_idx <= byte_idx_next;
      tx_latch <= tx_latch_next;
      tx_data  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    tx_latch_next = 1'b0;
    tx_data_next  = tx_data;
    addr_shifted  = rd_addr >> (8 * (ADDR_BYTES - 1 - int'(byte_idx)));
    unique case (state)
      ST_IDLE: begin
        if (!empty && uart_ready) begin
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (can_send) begin
          tx_latch_next = 1'b1;
          tx_data_next  = make_header(drop_pending, rd_cyctype);
          byte_idx_next = '0;
          state_next    = drop_pending ? ST_DROP : ST_ADDR;
        end
      end
      ST_DROP: begin
        if (can_send) begin
          tx_latch_next = 1'b1;
          tx_data_next  = drop_cnt;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (can_send) begin
          tx_latch_next = 1'b1;
          tx_data_next  = addr_shifted[7:0];
          if (byte_idx == LAST_BYTE) begin
            state_next = ST_DATA;
          end else begin
            byte_idx_next = byte_idx + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (can_send) begin
          tx_latch_next = 1'b1;
          tx_data_next  = rd_byte;
          state_next    = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // A drop coinciding with the report starts a fresh count of one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_pending <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (drop_report) begin
        drop_cnt     <= drop ? DROP_CNT_W'(1) : '0;
        drop_pending <= drop;
      end else if (drop) begin
        drop_pending <= 1'b1;
        if (drop_cnt != DROP_CNT_MAX) begin
          drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
      end
    end
  end

  assign uart_data  = tx_data;
  assign uart_latch = tx_latch;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lpc_record_fifo.sv
// Self-checking bench for lpc_record_fifo (ADDR_W=16, DEPTH_LOG2=2).
`default_nettype none

module tb_lpc_record_fifo;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_cyctype_dir;
  logic [15:0] in_addr;
  logic [7:0]  in_data;
  logic        in_latch;
  logic        uart_ready;
  logic [7:0]  uart_data;
  logic        uart_latch;
  logic        empty;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  lpc_record_fifo #(
    .ADDR_W       (16),
    .DEPTH_LOG2   (2),
    .FILTER_MASK  (32'h0000_FF00),
    .FILTER_MATCH (32'h0000_0000)
  ) dut (
    .clock          (clk),
    .reset          (rst_n),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_latch       (in_latch),
    .uart_ready     (uart_ready),
    .uart_data      (uart_data),
    .uart_latch     (uart_latch),
    .empty          (empty),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ct;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] exp_bytes;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp2 [17];
  logic [7:0] exp4 [17];
  logic [7:0] byte_q [$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         dbl_latch = 0;
  logic       prev_latch = 1'b0;

  always @(negedge clk) begin
    if (uart_latch) byte_q.push_back(uart_data);
    if (uart_latch && prev_latch) dbl_latch++;
    prev_latch = uart_latch;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] got_byte(input int i);
    if (i < byte_q.size()) return {24'h0, byte_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    byte_q.delete();
  endtask

  task automatic push(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d);
    in_cyctype_dir = ct;
    in_addr        = a;
    in_data        = d;
    in_latch       = 1'b1;
    tick();
    in_latch       = 1'b0;
    tick();
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (byte_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, (byte_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_latch_at(input string name, input int idx, input int budget);
    int k;
    k = 0;
    while (!(uart_latch && byte_q.size() == idx) && k < budget) begin
      tick();
      k++;
    end
    check(name, (k < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int sz;
    vecs[0] = '{ct: 4'h2, addr: 16'h0080, data: 8'h55, exp_bytes: 32'h02_00_80_55};
    vecs[1] = '{ct: 4'hF, addr: 16'hABCD, data: 8'h00, exp_bytes: 32'h0F_AB_CD_00};
    vecs[2] = '{ct: 4'h0, addr: 16'hFFFF, data: 8'hFF, exp_bytes: 32'h00_FF_FF_FF};
    vecs[3] = '{ct: 4'h9, addr: 16'h1234, data: 8'hC3, exp_bytes: 32'h09_12_34_C3};
    exp2 = '{8'h81, 8'h02, 8'h11, 8'h00, 8'hA0,
             8'h02, 8'h11, 8'h01, 8'hA1,
             8'h03, 8'h11, 8'h02, 8'hA2,
             8'h04, 8'h11, 8'h03, 8'hA3};
    exp4 = '{8'h87, 8'hFF, 8'h33, 8'h00, 8'h40,
             8'h07, 8'h33, 8'h01, 8'h41,
             8'h07, 8'h33, 8'h02, 8'h42,
             8'h07, 8'h33, 8'h03, 8'h43};

    in_cyctype_dir = '0;
    in_addr        = '0;
    in_data        = '0;
    in_latch       = 1'b0;
    uart_ready     = 1'b0;
    do_reset();

    check("rst_empty",      {31'h0, empty},      32'd1);
    check("rst_level",      {29'h0, level},      32'd0);
    check("rst_overflow",   {31'h0, overflow},   32'd0);
    check("rst_drop_count", {24'h0, drop_count}, 32'd0);
    check("rst_uart_latch", {31'h0, uart_latch}, 32'd0);
    check("rst_uart_data",  {24'h0, uart_data},  32'd0);

    // Single records, ready held high.
    uart_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      byte_q.delete();
      push(vecs[v].ct, vecs[v].addr, vecs[v].data);
      wait_bytes($sformatf("v%0d_wait", v), 4, 40);
      for (int j = 0; j < 4; j++) begin
        logic [31:0] e;
        e = vecs[v].exp_bytes >> (8 * (3 - j));
        check($sformatf("v%0d_byte%0d", v, j), got_byte(j), {24'h0, e[7:0]});
      end
      repeat (4) tick();
      check($sformatf("v%0d_count", v), byte_q.size(), 32'd4);
      check($sformatf("v%0d_empty", v), {31'h0, empty}, 32'd1);
      check($sformatf("v%0d_level", v), {29'h0, level}, 32'd0);
    end

    // Overflow with in-band drop report.
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(4'(i + 1), 16'h1100 + 16'(i), 8'hA0 + 8'(i));
    check("t2_level",      {29'h0, level},      32'd4);
    check("t2_overflow",   {31'h0, overflow},   32'd1);
    check("t2_drop_count", {24'h0, drop_count}, 32'd2);
    uart_ready = 1'b1;
    wait_bytes("t2_wait", 17, 200);
    for (int i = 0; i < 17; i++) check($sformatf("t2_byte%0d", i), got_byte(i), {24'h0, exp2[i]});
    repeat (6) tick();
    check("t2_count",      byte_q.size(),       32'd17);
    check("t2_drop_clear", {24'h0, drop_count}, 32'd0);
    check("t2_empty",      {31'h0, empty},      32'd1);

    // Push into a full FIFO during the retire cycle.
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'h5, 16'h2000 + 16'(i), 8'h10 + 8'(i));
    uart_ready = 1'b1;
    wait_latch_at("t3_sync", 3, 60);
    in_cyctype_dir = 4'h6;
    in_addr        = 16'h2004;
    in_data        = 8'h14;
    in_latch       = 1'b1;
    tick();
    in_latch = 1'b0;
    check("t3_level",      {29'h0, level},      32'd4);
    check("t3_overflow",   {31'h0, overflow},   32'd0);
    check("t3_drop_count", {24'h0, drop_count}, 32'd0);
    wait_bytes("t3_wait", 20, 200);
    check("t3_rec1_hdr", got_byte(4),  32'h05);
    check("t3_last_hdr", got_byte(16), 32'h06);
    check("t3_last_ahi", got_byte(17), 32'h20);
    check("t3_last_alo", got_byte(18), 32'h04);
    check("t3_last_dat", got_byte(19), 32'h14);

    // Drop counter saturation.
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'h7, 16'h3300 + 16'(i), 8'h40 + 8'(i));
    for (int i = 0; i < 300; i++) push(4'hE, 16'hEEEE, 8'hEE);
    check("t4_drop_sat", {24'h0, drop_count}, 32'd255);
    check("t4_overflow", {31'h0, overflow},   32'd1);
    check("t4_level",    {29'h0, level},      32'd4);
    uart_ready = 1'b1;
    wait_bytes("t4_wait", 17, 200);
    for (int i = 0; i < 17; i++) check($sformatf("t4_byte%0d", i), got_byte(i), {24'h0, exp4[i]});
    check("t4_drop_clear", {24'h0, drop_count}, 32'd0);

    // Reset in the middle of the address bytes.
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'h3, 16'h4400 + 16'(i), 8'h50 + 8'(i));
    check("t5_pre_overflow", {31'h0, overflow}, 32'd1);
    uart_ready = 1'b1;
    wait_latch_at("t5_sync", 2, 60);
    rst_n = 1'b0;
    tick();
    check("t5_empty",      {31'h0, empty},      32'd1);
    check("t5_level",      {29'h0, level},      32'd0);
    check("t5_overflow",   {31'h0, overflow},   32'd0);
    check("t5_uart_latch", {31'h0, uart_latch}, 32'd0);
    check("t5_drop_count", {24'h0, drop_count}, 32'd0);
    rst_n = 1'b1;
    sz = byte_q.size();
    repeat (20) tick();
    check("t5_no_more_bytes", byte_q.size(), sz);

`ifdef LPC_ADDR_FILTER_EN
    do_reset();
    uart_ready = 1'b1;
    push(4'h2, 16'h0080, 8'h55);
    push(4'h2, 16'h1080, 8'h66);
    wait_bytes("t6_wait", 4, 60);
    repeat (30) tick();
    check("t6_count",      byte_q.size(),       32'd4);
    check("t6_addr_lo",    got_byte(2),         32'h80);
    check("t6_data",       got_byte(3),         32'h55);
    check("t6_drop_count", {24'h0, drop_count}, 32'd0);
    check("t6_overflow",   {31'h0, overflow},   32'd0);
`endif

    check("latch_one_cycle", dbl_latch, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
